// File: rtl/lcd_bus_decoder.sv
// Passive monitor for a 4-bit HD44780-style LCD bus: rebuilds bytes from nibble strobes,
// tracks the DDRAM cursor and re-emits character writes as character-buffer writes.
module lcd_bus_decoder #(
    parameter int E_MIN_CYC = 4,
    parameter int ECNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lcd_data,
    input  logic [2:0] lcd_ctrl,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    output logic [6:0] cur_addr,
    output logic       four_bit,
    output logic       err
);

    localparam logic [1:0] ST_MODE8 = 2'd0;
    localparam logic [1:0] ST_HI    = 2'd1;
    localparam logic [1:0] ST_LO    = 2'd2;

    // Input stage: {RS, RW, E, DB7..DB4} registered every cycle.
    logic [6:0] bus_in;
    logic [6:0] bus_reg;

    assign bus_in = {lcd_ctrl, lcd_data};

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_in_reg
            always_ff @(posedge clk) begin
                if (rst) bus_reg[gi] <= 1'b0;
                else     bus_reg[gi] <= bus_in[gi];
            end
        end
    endgenerate

    logic       e_s;
    logic       rs_s;
    logic       rw_s;
    logic [3:0] nib_s;

    assign rs_s  = bus_reg[6];
    assign rw_s  = bus_reg[5];
    assign e_s   = bus_reg[4];
    assign nib_s = bus_reg[3:0];

    // E-high tracking: length of the pulse plus the last values seen while E was high.
    logic [ECNT_W-1:0] ecnt_reg;
    logic [3:0]        cap_nib_reg;
    logic              cap_rs_reg;
    logic              cap_rw_reg;
    logic              chg_reg;
    logic              strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            ecnt_reg    <= '0;
            cap_nib_reg <= 4'h0;
            cap_rs_reg  <= 1'b0;
            cap_rw_reg  <= 1'b0;
            chg_reg     <= 1'b0;
        end else if (e_s) begin
            if (ecnt_reg != '1) ecnt_reg <= ecnt_reg + 1'b1;
            cap_nib_reg <= nib_s;
            cap_rs_reg  <= rs_s;
            cap_rw_reg  <= rw_s;
            if (ecnt_reg == '0)
                chg_reg <= 1'b0;
            else if ((rs_s != cap_rs_reg) || (rw_s != cap_rw_reg))
                chg_reg <= 1'b1;
        end else begin
            ecnt_reg <= '0;
        end
    end

    assign strobe = !e_s && (ecnt_reg != '0);

    // Event stage: one registered record per falling edge of E.
    logic       ev_valid_reg;
    logic       ev_bad_reg;
    logic [3:0] ev_nib_reg;
    logic       ev_rs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid_reg <= 1'b0;
            ev_bad_reg   <= 1'b0;
            ev_nib_reg   <= 4'h0;
            ev_rs_reg    <= 1'b0;
        end else begin
            ev_valid_reg <= strobe;
            ev_bad_reg   <= (ecnt_reg < ECNT_W'(E_MIN_CYC)) || chg_reg || cap_rw_reg;
            ev_nib_reg   <= cap_nib_reg;
            ev_rs_reg    <= cap_rs_reg;
        end
    end

    // Execute stage.
    logic [1:0] state_reg;
    logic [3:0] hi_nib_reg;
    logic       hi_rs_reg;
    logic       incr_reg;
    logic [7:0] byte_c;
    logic       in_line1;
    logic       in_line2;
    logic [6:0] cur_step;

    always_comb begin
        byte_c   = {hi_nib_reg, ev_nib_reg};
        in_line1 = (cur_addr[6:4] == 3'b000);
        in_line2 = (cur_addr[6:4] == 3'b100);
        cur_step = incr_reg ? (cur_addr + 7'd1) : (cur_addr - 7'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_MODE8;
            hi_nib_reg <= 4'h0;
            hi_rs_reg  <= 1'b0;
            incr_reg   <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= 6'd0;
            wr_data    <= 8'h00;
            cmd_valid  <= 1'b0;
            cmd_data   <= 8'h00;
            cur_addr   <= 7'd0;
            four_bit   <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
            if (ev_valid_reg) begin
                if (ev_bad_reg) begin
                    err <= 1'b1;
                end else begin
                    case (state_reg)
                        ST_MODE8: begin
                            if (!ev_rs_reg && ev_nib_reg == 4'h2) begin
                                four_bit  <= 1'b1;
                                state_reg <= ST_HI;
                                cmd_valid <= 1'b1;
                                cmd_data  <= 8'h20;
                            end else if (!ev_rs_reg && ev_nib_reg == 4'h3) begin
                                cmd_valid <= 1'b1;
                                cmd_data  <= 8'h30;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        ST_HI: begin
                            hi_nib_reg <= ev_nib_reg;
                            hi_rs_reg  <= ev_rs_reg;
                            state_reg  <= ST_LO;
                        end
                        ST_LO: begin
                            state_reg <= ST_HI;
                            if (ev_rs_reg != hi_rs_reg) begin
                                err <= 1'b1;
                            end else if (ev_rs_reg) begin
                                if (in_line1 || in_line2) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= {1'b0, in_line2, cur_addr[3:0]};
                                    wr_data <= byte_c;
                                end else begin
                                    err <= 1'b1;
                                end
                                cur_addr <= cur_step;
                            end else begin
                                cmd_valid <= 1'b1;
                                cmd_data  <= byte_c;
                                casez (byte_c)
                                    8'b0000_0001: begin
                                        cur_addr <= 7'd0;
                                        incr_reg <= 1'b1;
                                    end
                                    8'b0000_001?: cur_addr <= 7'd0;
                                    8'b0000_01??: incr_reg <= byte_c[1];
                                    8'b001?_????: begin
                                        // DL=1 drops the link back to 8-bit mode.
                                        if (byte_c[4]) begin
                                            state_reg <= ST_MODE8;
                                            four_bit  <= 1'b0;
                                        end
                                    end
                                    8'b1???_????: cur_addr <= byte_c[6:0];
                                    default: ;
                                endcase
                            end
                        end
                        default: state_reg <= ST_MODE8;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: one nibble strobe per table record, checked against
// hand-computed outputs, plus hand-written reset sequences.
module tb_lcd_bus_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lcd_data;
    logic [2:0] lcd_ctrl;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic [6:0] cur_addr;
    logic       four_bit;
    logic       err;

    lcd_bus_decoder #(.E_MIN_CYC(4), .ECNT_W(8)) dut (
        .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cur_addr(cur_addr),
        .four_bit(four_bit), .err(err)
    );

    always #5 clk = ~clk;

    // mode: 0 = clean strobe, 1 = RS flipped while E high, 2 = RW=1
    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         ehigh;
        int         mode;
        logic       ecmd;
        logic [7:0] ecmd_data;
        logic       ewr;
        logic [5:0] ewr_addr;
        logic [7:0] ewr_data;
        int         eerr;
        logic [6:0] ecur;
        logic       efour;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   both_cnt = 0;

    always @(negedge clk) if (wr_en && cmd_valid) both_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic rs, input logic [3:0] nib, input int ehigh, input int mode,
                        input logic ecmd, input logic [7:0] ecd, input logic ewr,
                        input logic [5:0] ewa, input logic [7:0] ewd, input int eerr,
                        input logic [6:0] ecur, input logic efour);
        vec_t v;
        v.rs = rs; v.nib = nib; v.ehigh = ehigh; v.mode = mode;
        v.ecmd = ecmd; v.ecmd_data = ecd; v.ewr = ewr; v.ewr_addr = ewa; v.ewr_data = ewd;
        v.eerr = eerr; v.ecur = ecur; v.efour = efour;
        vq.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic       o_cmd, o_wr, stray;
        logic [7:0] o_cd, o_wd;
        logic [5:0] o_wa;
        int         errs;
        logic       rw;
        rw = (v.mode == 2);
        @(negedge clk);
        lcd_data = v.nib;
        lcd_ctrl = {v.rs, rw, 1'b0};
        @(posedge clk);
        @(negedge clk);
        lcd_ctrl[0] = 1'b1;
        if (v.mode == 1) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            lcd_ctrl[2] = ~v.rs;
            repeat (v.ehigh - 2) @(posedge clk);
        end else begin
            repeat (v.ehigh) @(posedge clk);
        end
        @(negedge clk);
        lcd_ctrl[0] = 1'b0;
        // First edge sampling E=0, then the pulse must land exactly two edges later.
        @(posedge clk); #1;
        errs = int'(err);
        stray = wr_en | cmd_valid;
        @(posedge clk); #1;
        errs += int'(err);
        stray |= wr_en | cmd_valid;
        @(posedge clk); #1;
        errs += int'(err);
        o_cmd = cmd_valid; o_cd = cmd_data; o_wr = wr_en; o_wa = wr_addr; o_wd = wr_data;
        @(posedge clk); #1;
        errs += int'(err);
        stray |= wr_en | cmd_valid;
        lcd_ctrl = 3'b000;
        check($sformatf("v%0d cmd_valid", idx), o_cmd, v.ecmd);
        if (v.ecmd) check($sformatf("v%0d cmd_data", idx), o_cd, v.ecmd_data);
        check($sformatf("v%0d wr_en", idx), o_wr, v.ewr);
        if (v.ewr) begin
            check($sformatf("v%0d wr_addr", idx), o_wa, v.ewr_addr);
            check($sformatf("v%0d wr_data", idx), o_wd, v.ewr_data);
        end
        check($sformatf("v%0d err_pulses", idx), errs, v.eerr);
        check($sformatf("v%0d off_cycle_pulse", idx), stray, 1'b0);
        check($sformatf("v%0d cur_addr", idx), cur_addr, v.ecur);
        check($sformatf("v%0d four_bit", idx), four_bit, v.efour);
    endtask

    task automatic hv(input logic rs, input logic [3:0] nib, input logic ecmd,
                      input logic [7:0] ecd, input logic [6:0] ecur, input logic efour,
                      input int idx);
        vec_t v;
        v.rs = rs; v.nib = nib; v.ehigh = 6; v.mode = 0;
        v.ecmd = ecmd; v.ecmd_data = ecd; v.ewr = 1'b0; v.ewr_addr = 6'd0; v.ewr_data = 8'h00;
        v.eerr = 0; v.ecur = ecur; v.efour = efour;
        run_vec(v, idx);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " wr_en"}, wr_en, 1'b0);
        check({tag, " wr_addr"}, wr_addr, 6'd0);
        check({tag, " wr_data"}, wr_data, 8'h00);
        check({tag, " cmd_valid"}, cmd_valid, 1'b0);
        check({tag, " cmd_data"}, cmd_data, 8'h00);
        check({tag, " cur_addr"}, cur_addr, 7'd0);
        check({tag, " four_bit"}, four_bit, 1'b0);
        check({tag, " err"}, err, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        lcd_data = 4'h0;
        lcd_ctrl = 3'b000;

        //   rs nib  eh md  cmd data   wr addr data  err cur    four
        addv(0, 4'h3, 6, 0, 1, 8'h30, 0, 6'd0, 8'h00, 0, 7'h00, 0);
        addv(0, 4'h3, 6, 0, 1, 8'h30, 0, 6'd0, 8'h00, 0, 7'h00, 0);
        addv(0, 4'h3, 6, 0, 1, 8'h30, 0, 6'd0, 8'h00, 0, 7'h00, 0);
        addv(0, 4'h2, 6, 0, 1, 8'h20, 0, 6'd0, 8'h00, 0, 7'h00, 1);
        addv(0, 4'h8, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h00, 1);
        addv(0, 4'h0, 6, 0, 1, 8'h80, 0, 6'd0, 8'h00, 0, 7'h00, 1);
        addv(1, 4'h4, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h00, 1);
        addv(1, 4'hC, 6, 0, 0, 8'h00, 1, 6'd0, 8'h4C, 0, 7'h01, 1);
        addv(0, 4'hC, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h01, 1);
        addv(0, 4'h0, 6, 0, 1, 8'hC0, 0, 6'd0, 8'h00, 0, 7'h40, 1);
        addv(1, 4'h4, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h40, 1);
        addv(1, 4'h1, 6, 0, 0, 8'h00, 1, 6'd16, 8'h41, 0, 7'h41, 1);
        addv(1, 4'h5, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h41, 1);
        addv(1, 4'h2, 6, 0, 0, 8'h00, 1, 6'd17, 8'h52, 0, 7'h42, 1);
        addv(0, 4'h8, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h42, 1);
        addv(0, 4'hF, 6, 0, 1, 8'h8F, 0, 6'd0, 8'h00, 0, 7'h0F, 1);
        addv(1, 4'h2, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h0F, 1);
        addv(1, 4'h0, 6, 0, 0, 8'h00, 1, 6'd15, 8'h20, 0, 7'h10, 1);
        addv(1, 4'h2, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h10, 1);
        addv(1, 4'h1, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h11, 1);
        addv(0, 4'h0, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h11, 1);
        addv(0, 4'h4, 6, 0, 1, 8'h04, 0, 6'd0, 8'h00, 0, 7'h11, 1);
        addv(1, 4'h4, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h11, 1);
        addv(1, 4'h1, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h10, 1);
        addv(0, 4'h8, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h10, 1);
        addv(0, 4'h5, 6, 0, 1, 8'h85, 0, 6'd0, 8'h00, 0, 7'h05, 1);
        addv(1, 4'h4, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h05, 1);
        addv(1, 4'h2, 6, 0, 0, 8'h00, 1, 6'd5, 8'h42, 0, 7'h04, 1);
        addv(0, 4'h0, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h04, 1);
        addv(0, 4'h6, 6, 0, 1, 8'h06, 0, 6'd0, 8'h00, 0, 7'h04, 1);
        // Protocol violations in the HI phase: each must leave the phase alone.
        addv(0, 4'h5, 2, 0, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h04, 1);
        addv(0, 4'h5, 3, 0, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h04, 1);
        addv(0, 4'h5, 6, 1, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h04, 1);
        addv(0, 4'h5, 6, 2, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h04, 1);
        addv(0, 4'h0, 4, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h04, 1);
        addv(0, 4'h1, 6, 0, 1, 8'h01, 0, 6'd0, 8'h00, 0, 7'h00, 1);
        addv(0, 4'h8, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h00, 1);
        addv(1, 4'h0, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h00, 1);
        addv(0, 4'h3, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 0, 7'h00, 1);
        addv(0, 4'h0, 6, 0, 1, 8'h30, 0, 6'd0, 8'h00, 0, 7'h00, 0);
        addv(0, 4'h8, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h00, 0);
        addv(1, 4'h2, 6, 0, 0, 8'h00, 0, 6'd0, 8'h00, 1, 7'h00, 0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

        // Mid-byte reset: cursor moved, HI nibble pending, then one cycle of rst.
        hv(0, 4'h2, 1, 8'h20, 7'h00, 1, 100);
        hv(0, 4'h8, 0, 8'h00, 7'h00, 1, 101);
        hv(0, 4'hA, 1, 8'h8A, 7'h0A, 1, 102);
        hv(0, 4'h4, 0, 8'h00, 7'h0A, 1, 103);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midbyte_reset");
        @(negedge clk);
        rst = 1'b0;
        // A lone nibble 2 is accepted as function set only if the decoder is back in MODE8.
        hv(0, 4'h2, 1, 8'h20, 7'h00, 1, 104);
        hv(0, 4'h8, 0, 8'h00, 7'h00, 1, 105);
        hv(0, 4'hA, 1, 8'h8A, 7'h0A, 1, 106);
        hv(0, 4'h0, 0, 8'h00, 7'h0A, 1, 107);
        hv(0, 4'h1, 1, 8'h01, 7'h00, 1, 108);

        check("wr_en_and_cmd_valid_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
